// File: rtl/iic_arb_pkg.sv
// Shared constants for the IIC bus arbiter: FSM encodings, widths and touch-controller register map.
package iic_arb_pkg;

  typedef logic [1:0] arb_state_t;

  localparam arb_state_t ST_IDLE  = 2'd0;
  localparam arb_state_t ST_GRANT = 2'd1;
  localparam arb_state_t ST_XFER  = 2'd2;
  localparam arb_state_t ST_DONE  = 2'd3;

  localparam int BYTE_W = 8;

  localparam logic [15:0] TS_CTRL_ADDR   = 16'h8040;
  localparam logic [15:0] TS_STATUS_ADDR = 16'h814E;
  localparam logic [15:0] TS_POINTS_ADDR = 16'h8150;

endpackage

// File: rtl/iic_rr_pick.sv
// Combinational round-robin picker: first eligible requester strictly after the last winner.
module iic_rr_pick #(
  parameter int NREQ  = 2,
  parameter int IDX_W = 1
) (
  input  logic [NREQ-1:0]  req,
  input  logic [NREQ-1:0]  mask,
  input  logic [IDX_W-1:0] last,
  output logic [NREQ-1:0]  pick_oh,
  output logic [IDX_W-1:0] pick_idx,
  output logic             pick_vld
);

  logic [NREQ-1:0]  elig;
  logic [IDX_W-1:0] cand;

  assign elig = req & ~mask;

  always_comb begin
    pick_oh  = '0;
    pick_idx = '0;
    pick_vld = 1'b0;
    cand     = '0;
    for (int k = 1; k <= NREQ; k++) begin
      cand = IDX_W'((int'(last) + k) % NREQ);
      if (!pick_vld && elig[cand]) begin
        pick_vld      = 1'b1;
        pick_idx      = cand;
        pick_oh[cand] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/iic_bus_arbiter.sv
// Lock-style round-robin owner of one IIC engine and its 64x8 transfer buffer.
// Optional owner watchdog enabled by defining IIC_ARB_WDOG_EN.
module iic_bus_arbiter
  import iic_arb_pkg::*;
#(
  parameter int NREQ     = 2,
  parameter int ADDR_W   = 16,
  parameter int LEN_W    = 6,
  parameter int BUF_AW   = 6,
  parameter int HOLD_MAX = 1000000
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic [NREQ-1:0]          req,
  output logic [NREQ-1:0]          gnt,
  input  logic [NREQ-1:0]          start,
  input  logic [NREQ-1:0]          r_we,
  input  logic [NREQ*ADDR_W-1:0]   r_addr,
  input  logic [NREQ*LEN_W-1:0]    r_len,
  output logic [NREQ-1:0]          done,
  input  logic [NREQ-1:0]          rb_we,
  input  logic [NREQ*BUF_AW-1:0]   rb_addr,
  input  logic [NREQ*BYTE_W-1:0]   rb_din,
  output logic [BYTE_W-1:0]        rb_dout,
  output logic                     iic_en,
  output logic                     iic_we,
  output logic [ADDR_W-1:0]        iic_addr,
  output logic [LEN_W-1:0]         iic_len,
  input  logic                     iic_rdy,
  input  logic                     e_buf_we,
  input  logic [BUF_AW-1:0]        e_buf_addr,
  input  logic [BYTE_W-1:0]        e_buf_wdata,
  output logic [BYTE_W-1:0]        e_buf_rdata,
  output logic                     wdog_err
);

  localparam int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;

  if (NREQ < 2 || NREQ > 4 || HOLD_MAX < 1) begin : g_bad_param
    $error("iic_bus_arbiter: NREQ must be 2..4 and HOLD_MAX >= 1");
  end

  arb_state_t       state;
  logic [IDX_W-1:0] owner;
  logic [IDX_W-1:0] last_win;
  logic             zlen_q;

  logic [NREQ-1:0]  pick_oh;
  logic [IDX_W-1:0] pick_idx;
  logic             pick_vld;
  logic [NREQ-1:0]  arb_mask;
  logic             wdog_fire;

  logic [ADDR_W-1:0] addr_a  [NREQ];
  logic [LEN_W-1:0]  len_a   [NREQ];
  logic [BUF_AW-1:0] baddr_a [NREQ];
  logic [BYTE_W-1:0] bdin_a  [NREQ];

  for (genvar i = 0; i < NREQ; i++) begin : g_unpack
    assign addr_a[i]  = r_addr[i*ADDR_W +: ADDR_W];
    assign len_a[i]   = r_len[i*LEN_W +: LEN_W];
    assign baddr_a[i] = rb_addr[i*BUF_AW +: BUF_AW];
    assign bdin_a[i]  = rb_din[i*BYTE_W +: BYTE_W];
  end

  logic own_req, own_start;
  assign own_req   = req[owner];
  assign own_start = start[owner];

  iic_rr_pick #(
    .NREQ  (NREQ),
    .IDX_W (IDX_W)
  ) u_pick (
    .req      (req),
    .mask     (arb_mask),
    .last     (last_win),
    .pick_oh  (pick_oh),
    .pick_idx (pick_idx),
    .pick_vld (pick_vld)
  );

  // A zero-length start spends one XFER cycle with the engine untouched before DONE.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state    <= ST_IDLE;
      owner    <= '0;
      last_win <= IDX_W'(NREQ - 1);
      gnt      <= '0;
      zlen_q   <= 1'b0;
      iic_we   <= 1'b0;
      iic_addr <= '0;
      iic_len  <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (pick_vld) begin
            owner <= pick_idx;
            gnt   <= pick_oh;
            state <= ST_GRANT;
          end
        end
        ST_GRANT: begin
          if (!own_req || wdog_fire) begin
            gnt      <= '0;
            last_win <= owner;
            state    <= ST_IDLE;
          end else if (own_start) begin
            iic_we   <= r_we[owner];
            iic_addr <= addr_a[owner];
            iic_len  <= len_a[owner];
            zlen_q   <= (len_a[owner] == '0);
            state    <= ST_XFER;
          end
        end
        ST_XFER: begin
          if (zlen_q || iic_rdy) state <= ST_DONE;
        end
        default: state <= ST_GRANT;
      endcase
    end
  end

  assign iic_en = (state == ST_XFER) && !zlen_q && !iic_rdy;
  assign done   = (state == ST_DONE) ? gnt : '0;

`ifdef IIC_ARB_WDOG_EN
  localparam int WCNT_W = $clog2(HOLD_MAX + 1);

  logic [WCNT_W-1:0] wcnt;
  logic [NREQ-1:0]   mask_q;
  logic              wdog_err_q;

  assign wdog_fire = (state == ST_GRANT) && own_req && !own_start &&
                     (wcnt == WCNT_W'(HOLD_MAX - 1));

  // Offender stays masked until it lets go of req, so a stuck owner cannot re-win at once.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wcnt       <= '0;
      mask_q     <= '0;
      wdog_err_q <= 1'b0;
    end else begin
      wdog_err_q <= wdog_fire;
      if ((state != ST_GRANT) || !own_req || own_start || wdog_fire) wcnt <= '0;
      else wcnt <= wcnt + 1'b1;
      for (int i = 0; i < NREQ; i++) begin
        if (!req[i]) mask_q[i] <= 1'b0;
        else if (wdog_fire && (owner == IDX_W'(i))) mask_q[i] <= 1'b1;
      end
    end
  end

  assign arb_mask = mask_q;
  assign wdog_err = wdog_err_q;
`else
  assign wdog_fire = 1'b0;
  assign arb_mask  = '0;
  assign wdog_err  = 1'b0;
`endif

  logic              eng_sel;
  logic              buf_we;
  logic [BUF_AW-1:0] buf_addr;
  logic [BYTE_W-1:0] buf_din;
  logic [BYTE_W-1:0] mem [2**BUF_AW];

  assign eng_sel = (state == ST_XFER) && !zlen_q;

  always_comb begin
    if (eng_sel) begin
      buf_we   = e_buf_we;
      buf_addr = e_buf_addr;
      buf_din  = e_buf_wdata;
    end else begin
      buf_we   = (|gnt) && rb_we[owner];
      buf_addr = baddr_a[owner];
      buf_din  = bdin_a[owner];
    end
  end

  always_ff @(posedge clk) begin
    if (buf_we) mem[buf_addr] <= buf_din;
  end

  assign rb_dout     = mem[buf_addr];
  assign e_buf_rdata = mem[buf_addr];

endmodule

// File: tb/tb_iic_bus_arbiter.sv
// Bench for iic_bus_arbiter: directed scenarios plus randomized ownership/transfer rounds.
module tb_iic_bus_arbiter;
  import iic_arb_pkg::*;

  localparam int NREQ = 2;

  logic         clk = 1'b0;
  logic         rstn;
  logic [1:0]   req, gnt, start, r_we, done, rb_we;
  logic [31:0]  r_addr;
  logic [11:0]  r_len, rb_addr;
  logic [15:0]  rb_din;
  logic [7:0]   rb_dout, e_buf_wdata, e_buf_rdata;
  logic         iic_en, iic_we, iic_rdy, e_buf_we, wdog_err;
  logic [15:0]  iic_addr;
  logic [5:0]   iic_len, e_buf_addr;

  int n_cmp = 0;
  int n_err = 0;
  int m_last;
  logic [7:0] mem_m [64];

  always #5 clk = ~clk;

  iic_bus_arbiter #(
    .NREQ(NREQ), .ADDR_W(16), .LEN_W(6), .BUF_AW(6), .HOLD_MAX(16)
  ) dut (
    .clk(clk), .rstn(rstn), .req(req), .gnt(gnt), .start(start), .r_we(r_we),
    .r_addr(r_addr), .r_len(r_len), .done(done), .rb_we(rb_we), .rb_addr(rb_addr),
    .rb_din(rb_din), .rb_dout(rb_dout), .iic_en(iic_en), .iic_we(iic_we),
    .iic_addr(iic_addr), .iic_len(iic_len), .iic_rdy(iic_rdy), .e_buf_we(e_buf_we),
    .e_buf_addr(e_buf_addr), .e_buf_wdata(e_buf_wdata), .e_buf_rdata(e_buf_rdata),
    .wdog_err(wdog_err)
  );

  initial begin
    #2000000;
    $display("FAIL timeout: bench did not reach its summary");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Round-robin rule: first requester set strictly after the last winner, wrapping.
  function automatic int rr_pick(input logic [1:0] rq, input int last);
    for (int k = 1; k <= NREQ; k++)
      if (rq[(last + k) % NREQ]) return (last + k) % NREQ;
    return -1;
  endfunction

  task automatic buf_write(input int r, input logic [5:0] a, input logic [7:0] d, input bit is_owner);
    rb_we[r] = 1'b1;
    rb_addr[r*6 +: 6] = a;
    rb_din[r*8 +: 8] = d;
    tick();
    rb_we[r] = 1'b0;
    if (is_owner) mem_m[a] = d;
  endtask

  task automatic read_check(input int r, input logic [5:0] a);
    rb_addr[r*6 +: 6] = a;
    #1;
    check("rb_dout", {24'd0, rb_dout}, {24'd0, mem_m[a]});
  endtask

  task automatic do_xfer(input int r, input logic we, input logic [15:0] addr, input logic [5:0] len,
                         input int lat, input logic [7:0] eng_byte, input logic [5:0] eng_ptr);
    r_we[r] = we;
    r_addr[r*16 +: 16] = addr;
    r_len[r*6 +: 6] = len;
    start[r] = 1'b1;
    tick();
    start[r] = 1'b0;
    if (len == 6'd0) begin
      check("zlen_en_c1", {31'd0, iic_en}, 32'd0);
      check("zlen_done_c1", {30'd0, done}, 32'd0);
      tick();
      check("zlen_done_c2", {30'd0, done}, 32'(1 << r));
      check("zlen_en_c2", {31'd0, iic_en}, 32'd0);
      tick();
      check("zlen_done_clr", {30'd0, done}, 32'd0);
    end else begin
      check("xfer_en", {31'd0, iic_en}, 32'd1);
      check("xfer_we", {31'd0, iic_we}, {31'd0, we});
      check("xfer_addr", {16'd0, iic_addr}, {16'd0, addr});
      check("xfer_len", {26'd0, iic_len}, {26'd0, len});
      e_buf_addr = eng_ptr;
      if (we) begin
        #1;
        check("eng_rdata", {24'd0, e_buf_rdata}, {24'd0, mem_m[eng_ptr]});
      end else begin
        e_buf_we = 1'b1;
        e_buf_wdata = eng_byte;
        mem_m[eng_ptr] = eng_byte;
      end
      for (int k = 1; k < lat; k++) begin
        tick();
        e_buf_we = 1'b0;
        check("xfer_hold_en", {31'd0, iic_en}, 32'd1);
        check("xfer_hold_addr", {16'd0, iic_addr}, {16'd0, addr});
      end
      iic_rdy = 1'b1;
      #1;
      check("rdy_en_drop", {31'd0, iic_en}, 32'd0);
      check("rdy_no_done", {30'd0, done}, 32'd0);
      tick();
      iic_rdy = 1'b0;
      e_buf_we = 1'b0;
      check("done_pulse", {30'd0, done}, 32'(1 << r));
      check("done_en_low", {31'd0, iic_en}, 32'd0);
      tick();
      check("done_clr", {30'd0, done}, 32'd0);
    end
  endtask

  initial begin
    rstn = 1'b0;
    req = '0; start = '0; r_we = '0; r_addr = '0; r_len = '0;
    rb_we = '0; rb_addr = '0; rb_din = '0;
    iic_rdy = 1'b0; e_buf_we = 1'b0; e_buf_addr = '0; e_buf_wdata = '0;
    m_last = NREQ - 1;
    repeat (3) tick();
    check("rst_gnt", {30'd0, gnt}, 32'd0);
    check("rst_done", {30'd0, done}, 32'd0);
    check("rst_en", {31'd0, iic_en}, 32'd0);
    check("rst_we", {31'd0, iic_we}, 32'd0);
    check("rst_addr", {16'd0, iic_addr}, 32'd0);
    check("rst_len", {26'd0, iic_len}, 32'd0);
    check("rst_wdog", {31'd0, wdog_err}, 32'd0);
    rstn = 1'b1;
    tick();

    // Simultaneous requests, hand-over and re-request.
    req = 2'b11;
    tick();
    check("rr_first", {30'd0, gnt}, 32'(1 << rr_pick(2'b11, m_last)));
    req[0] = 1'b0;
    tick();
    check("rr_release", {30'd0, gnt}, 32'd0);
    m_last = 0;
    tick();
    check("rr_second", {30'd0, gnt}, 32'(1 << rr_pick(2'b10, m_last)));
    req[1] = 1'b0;
    tick();
    check("rr_release2", {30'd0, gnt}, 32'd0);
    m_last = 1;
    req = 2'b11;
    tick();
    check("rr_rerequest", {30'd0, gnt}, 32'b01);
    req[1] = 1'b0;

    for (int i = 0; i < 64; i++) buf_write(0, 6'(i), 8'(i) ^ 8'h5A, 1'b1);

    // Status read: engine deposits a byte the owner then reads back.
    do_xfer(0, 1'b0, TS_STATUS_ADDR, 6'd1, 3, 8'hA5, 6'd5);
    read_check(0, 6'd5);

    // Owner writes control byte; non-owner write to the same slot must not land.
    buf_write(0, 6'd0, 8'h02, 1'b1);
    buf_write(1, 6'd0, 8'hFF, 1'b0);
    read_check(0, 6'd0);
    do_xfer(0, 1'b1, TS_CTRL_ADDR, 6'd1, 2, 8'h00, 6'd0);

    do_xfer(0, 1'b0, TS_POINTS_ADDR, 6'd0, 1, 8'h00, 6'd0);

    // Start from a non-owner is ignored.
    r_len[6 +: 6] = 6'd5;
    start[1] = 1'b1;
    tick();
    start[1] = 1'b0;
    check("nonowner_start_en", {31'd0, iic_en}, 32'd0);
    tick();
    check("nonowner_start_done", {30'd0, done}, 32'd0);
    check("nonowner_start_gnt", {30'd0, gnt}, 32'b01);

    // Owner drops req mid-transfer: transfer finishes, release follows the GRANT revisit.
    r_we[0] = 1'b1; r_addr[15:0] = TS_CTRL_ADDR; r_len[5:0] = 6'd2;
    start[0] = 1'b1;
    tick();
    start[0] = 1'b0;
    req[0] = 1'b0;
    check("drop_en_c1", {31'd0, iic_en}, 32'd1);
    tick();
    check("drop_en_c2", {31'd0, iic_en}, 32'd1);
    iic_rdy = 1'b1;
    tick();
    iic_rdy = 1'b0;
    check("drop_done", {30'd0, done}, 32'b01);
    tick();
    check("drop_gnt_hold", {30'd0, gnt}, 32'b01);
    tick();
    check("drop_gnt_clr", {30'd0, gnt}, 32'd0);
    m_last = 0;

    // Randomized ownership rounds.
    for (int it = 0; it < 30; it++) begin
      logic [1:0] rs;
      int w, w2, ntx;
      rs = 2'($urandom_range(1, 3));
      req = rs;
      tick();
      w = rr_pick(rs, m_last);
      check("rnd_gnt", {30'd0, gnt}, 32'(1 << w));
      ntx = $urandom_range(1, 3);
      for (int t = 0; t < ntx; t++) begin
        buf_write(w, 6'($urandom), 8'($urandom), 1'b1);
        buf_write(1 - w, 6'($urandom), 8'($urandom), 1'b0);
        do_xfer(w, 1'($urandom_range(0, 1)), 16'($urandom), 6'($urandom_range(0, 4)),
                $urandom_range(1, 4), 8'($urandom), 6'($urandom));
        read_check(w, 6'($urandom));
      end
      req[w] = 1'b0;
      tick();
      check("rnd_release", {30'd0, gnt}, 32'd0);
      m_last = w;
      rs[w] = 1'b0;
      if (rs != 2'b00) begin
        tick();
        w2 = rr_pick(rs, m_last);
        check("rnd_next_gnt", {30'd0, gnt}, 32'(1 << w2));
        req = '0;
        tick();
        check("rnd_release2", {30'd0, gnt}, 32'd0);
        m_last = w2;
      end
    end

    // Owner idling in GRANT with a competitor waiting.
    begin
      int w, o;
      req = 2'b11;
      tick();
      w = rr_pick(2'b11, m_last);
      o = 1 - w;
      check("idle_gnt", {30'd0, gnt}, 32'(1 << w));
      for (int k = 1; k < 16; k++) begin
        tick();
        check("idle_no_wdog", {31'd0, wdog_err}, 32'd0);
      end
      tick();
`ifdef IIC_ARB_WDOG_EN
      check("wdog_pulse", {31'd0, wdog_err}, 32'd1);
      check("wdog_gnt_clr", {30'd0, gnt}, 32'd0);
      tick();
      check("wdog_pulse_end", {31'd0, wdog_err}, 32'd0);
      check("wdog_other_gnt", {30'd0, gnt}, 32'(1 << o));
      m_last = w;
      req = '0;
      tick();
      check("wdog_release", {30'd0, gnt}, 32'd0);
      m_last = o;
`else
      check("nowdog_err", {31'd0, wdog_err}, 32'd0);
      check("nowdog_gnt", {30'd0, gnt}, 32'(1 << w));
      tick();
      check("nowdog_hold", {30'd0, gnt}, 32'(1 << w));
      req = '0;
      tick();
      check("nowdog_release", {30'd0, gnt}, 32'd0);
      m_last = w;
`endif
    end

    // Reset asserted in the middle of a transfer.
    req = 2'b01;
    tick();
    check("rst_xfer_gnt", {30'd0, gnt}, 32'(1 << rr_pick(2'b01, m_last)));
    r_we[0] = 1'b1; r_addr[15:0] = 16'h1234; r_len[5:0] = 6'd3;
    start[0] = 1'b1;
    tick();
    start[0] = 1'b0;
    check("rst_xfer_en", {31'd0, iic_en}, 32'd1);
    rstn = 1'b0;
    #1;
    check("midrst_gnt", {30'd0, gnt}, 32'd0);
    check("midrst_en", {31'd0, iic_en}, 32'd0);
    check("midrst_we", {31'd0, iic_we}, 32'd0);
    check("midrst_addr", {16'd0, iic_addr}, 32'd0);
    check("midrst_len", {26'd0, iic_len}, 32'd0);
    check("midrst_done", {30'd0, done}, 32'd0);
    req = '0;
    tick();
    rstn = 1'b1;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
